// File: rtl/field_select_fsm.sv
// Adjust-mode controller: center toggles ADJUST, left/right walk a one-hot field enable with wrap.
// Optional inactivity auto-exit is built when FIELD_TIMEOUT_EN is defined.
module field_select_fsm #(
  parameter int NUM_FIELDS     = 4,
  parameter int START_FIELD    = 0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          left,
  input  logic                          right,
  input  logic                          center,
  output logic                          adjust,
  output logic [NUM_FIELDS-1:0]         en,
  output logic [$clog2(NUM_FIELDS)-1:0] sel,
  output logic                          exit_pulse
);
  localparam int SW = $clog2(NUM_FIELDS);
  localparam logic [SW-1:0] START_SEL = SW'(START_FIELD);
  localparam logic [SW-1:0] LAST_SEL  = SW'(NUM_FIELDS - 1);

  typedef enum logic {IDLE = 1'b0, ADJUST = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [NUM_FIELDS-1:0] en_q, en_d;
  logic                  exit_q, exit_d;

`ifdef FIELD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    exit_d  = 1'b0;
`ifdef FIELD_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (center) begin
          state_d = ADJUST;
          sel_d   = START_SEL;
`ifdef FIELD_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ADJUST: begin
        if (center) begin
          state_d = IDLE;
          exit_d  = 1'b1;
        end else if (left || right) begin
          // both pressed counts as activity but moves nothing
          if (right && !left)
            sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + SW'(1);
          else if (left && !right)
            sel_d = (sel_q == '0) ? LAST_SEL : sel_q - SW'(1);
`ifdef FIELD_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
`ifdef FIELD_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          exit_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // per-field enable decode of the next state, so en is a plain register
  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_en
    assign en_d[i] = (state_d == ADJUST) && (sel_d == SW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= START_SEL;
      en_q    <= '0;
      exit_q  <= 1'b0;
`ifdef FIELD_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      exit_q  <= exit_d;
`ifdef FIELD_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign adjust     = (state_q == ADJUST);
  assign en         = en_q;
  assign sel        = sel_q;
  assign exit_pulse = exit_q;
endmodule

// File: tb/tb_field_select_fsm.sv
// Directed bench for field_select_fsm (NUM_FIELDS=4, START_FIELD=0, TIMEOUT_CYCLES=8).
// Observations are packed as {adjust, en[3:0], sel[1:0], exit_pulse}.
module tb_field_select_fsm;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left = 1'b0, right = 1'b0, center = 1'b0;
  logic       adjust, exit_pulse;
  logic [3:0] en;
  logic [1:0] sel;
  int         passed = 0, total = 0;

  field_select_fsm #(.NUM_FIELDS(4), .START_FIELD(0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .center(center),
    .adjust(adjust), .en(en), .sel(sel), .exit_pulse(exit_pulse)
  );

  always #5 clk = ~clk;

  // drive on negedge, return 1 time unit after the capturing posedge
  task automatic cyc(input logic l, input logic r, input logic c);
    @(negedge clk);
    left = l; right = r; center = c;
    @(posedge clk);
    #1;
    left = 1'b0; right = 1'b0; center = 1'b0;
  endtask

  function automatic logic [7:0] obs();
    return {adjust, en, sel, exit_pulse};
  endfunction

  task automatic test_reset();
    logic [7:0] o;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(i[0], ~i[0], i[1]);
      o = obs();
      total++;
      if (o !== 8'b0_0000_00_0) $display("FAIL reset[%0d] got %b want %b", i, o, 8'b0_0000_00_0);
      else passed++;
    end
    rst = 1'b0;
  endtask

  task automatic test_forward_wrap();
    logic [7:0] o, e;
    logic [3:0] exp_en [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    cyc(0, 0, 1);
    o = obs(); total++;
    if (o !== 8'b1_0001_00_0) $display("FAIL entry got %b want %b", o, 8'b1_0001_00_0);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0);
      e = {1'b1, exp_en[i], exp_sel[i], 1'b0};
      o = obs(); total++;
      if (o !== e) $display("FAIL fwd_step[%0d] got %b want %b", i, o, e);
      else passed++;
      cyc(0, 0, 0);
      o = obs(); total++;
      if (o !== e) $display("FAIL fwd_hold[%0d] got %b want %b", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_backward_simul();
    logic [7:0] o;
    cyc(1, 0, 0);
    o = obs(); total++;
    if (o !== 8'b1_1000_11_0) $display("FAIL back_wrap got %b want %b", o, 8'b1_1000_11_0);
    else passed++;
    cyc(1, 1, 0);
    o = obs(); total++;
    if (o !== 8'b1_1000_11_0) $display("FAIL left_right got %b want %b", o, 8'b1_1000_11_0);
    else passed++;
    cyc(1, 0, 1);
    o = obs(); total++;
    if (o !== 8'b0_0000_11_1) $display("FAIL left_center got %b want %b", o, 8'b0_0000_11_1);
    else passed++;
    cyc(0, 0, 0);
    o = obs(); total++;
    if (o !== 8'b0_0000_11_0) $display("FAIL exit_one_cycle got %b want %b", o, 8'b0_0000_11_0);
    else passed++;
    cyc(0, 1, 0);
    o = obs(); total++;
    if (o !== 8'b0_0000_11_0) $display("FAIL idle_ignores_dir got %b want %b", o, 8'b0_0000_11_0);
    else passed++;
  endtask

`ifdef FIELD_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] o, e;
    cyc(0, 0, 1);
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 0, 0);
      e = (k < 8) ? 8'b1_0001_00_0 : (k == 8) ? 8'b0_0000_00_1 : 8'b0_0000_00_0;
      o = obs(); total++;
      if (o !== e) $display("FAIL timeout[%0d] got %b want %b", k, o, e);
      else passed++;
    end
    cyc(0, 0, 1);
    for (int k = 1; k <= 6; k++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    o = obs(); total++;
    if (o !== 8'b1_0010_01_0) $display("FAIL timeout_kick got %b want %b", o, 8'b1_0010_01_0);
    else passed++;
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 0, 0);
      e = (k < 8) ? 8'b1_0010_01_0 : (k == 8) ? 8'b0_0000_01_1 : 8'b0_0000_01_0;
      o = obs(); total++;
      if (o !== e) $display("FAIL timeout_re[%0d] got %b want %b", k, o, e);
      else passed++;
    end
  endtask
`else
  task automatic test_no_timeout();
    logic [7:0] o;
    int bad = 0;
    cyc(0, 0, 1);
    for (int k = 1; k <= 100; k++) begin
      cyc(0, 0, 0);
      o = obs(); total++;
      if (o !== 8'b1_0001_00_0) begin
        bad++;
        if (bad <= 5) $display("FAIL no_timeout[%0d] got %b want %b", k, o, 8'b1_0001_00_0);
      end else passed++;
    end
    cyc(0, 0, 1);
    o = obs(); total++;
    if (o !== 8'b0_0000_00_1) $display("FAIL center_exit got %b want %b", o, 8'b0_0000_00_1);
    else passed++;
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] o;
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    o = obs(); total++;
    if (o !== 8'b1_0010_01_0) $display("FAIL entry_then_right got %b want %b", o, 8'b1_0010_01_0);
    else passed++;
    cyc(0, 1, 0);
    o = obs(); total++;
    if (o !== 8'b1_0100_10_0) $display("FAIL b2b_right got %b want %b", o, 8'b1_0100_10_0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] o;
    rst = 1'b1;
    cyc(0, 1, 1);
    rst = 1'b0;
    o = obs(); total++;
    if (o !== 8'b0_0000_00_0) $display("FAIL reset_mid got %b want %b", o, 8'b0_0000_00_0);
    else passed++;
    cyc(0, 0, 0);
    o = obs(); total++;
    if (o !== 8'b0_0000_00_0) $display("FAIL reset_mid_after got %b want %b", o, 8'b0_0000_00_0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_forward_wrap();
    test_backward_simul();
`ifdef FIELD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/field_select_fsm.md
# field_select_fsm

Parametrised adjust-mode controller for the alarm-clock front panel. It takes debounced, single-cycle left/right/center button pulses and enters or leaves adjust mode. In adjust mode it moves a one-hot enable across NUM_FIELDS time fields, wrapping at both ends. An optional inactivity timeout drops back to normal display mode. It sits between the push-button conditioning logic and the field counters (minutes, hours, alarm fields) that consume en.

## Interface
- NUM_FIELDS, 4: number of adjustable fields; width of en; legal range 2..16.
- START_FIELD, 0: field index selected on entry to adjust mode; 0..NUM_FIELDS-1.
- TIMEOUT_CYCLES, 1000: consecutive no-input ADJUST cycles before auto-exit; must be at least 2. Used only with FIELD_TIMEOUT_EN.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- left  in  1  one-cycle pulse: select the previous field.
- right  in  1  one-cycle pulse: select the next field.
- center  in  1  one-cycle pulse: toggle adjust mode.
- adjust  out  1  high while in ADJUST state.
- en  out  NUM_FIELDS  one-hot field enable in ADJUST; all zero in IDLE.
- sel  out  $clog2(NUM_FIELDS)  current field index.
- exit_pulse  out  1  one-cycle pulse on the cycle after any ADJUST→IDLE transition.

## Operation
- States: IDLE and ADJUST. All outputs are registered.
- Reset values: state=IDLE, adjust=0, en=0, sel=START_FIELD, exit_pulse=0, timeout counter=0.
- IDLE:
  - left and right are ignored.
  - center → ADJUST; sel loads START_FIELD; timeout counter clears.
- ADJUST, inputs in priority order:
  - center → IDLE; sel holds its value; exit_pulse=1.
  - left and right both high → no move; treated as activity, so the counter clears.
  - right only → sel = (sel==NUM_FIELDS-1) ? 0 : sel+1; counter clears.
  - left only → sel = (sel==0) ? NUM_FIELDS-1 : sel-1; counter clears.
  - no input → counter increments (timeout build only).
- en = adjust ? (1 << sel) : 0. en is never multi-hot.
- Timeout (FIELD_TIMEOUT_EN only):
  - Counter width is $clog2(TIMEOUT_CYCLES+1); it never wraps.
  - When the counter equals TIMEOUT_CYCLES-1 and the current cycle has no input, the FSM goes to IDLE and exit_pulse=1.
  - Net effect: exit happens after exactly TIMEOUT_CYCLES consecutive idle ADJUST cycles.
  - A center pulse on the same cycle is handled as a center exit. Only one exit_pulse is produced.
- Reset mid-ADJUST: rst overrides every input on that edge and forces the reset values. No exit_pulse is generated.

## Timing
- Latency: an input pulse sampled at edge k updates state, adjust, en, sel and exit_pulse immediately after edge k. That is one cycle of latency; there is no combinational input-to-output path.
- A center pulse in IDLE and a direction pulse on the next cycle: the direction pulse takes effect, because the FSM is already in ADJUST on that cycle.
- Back-to-back right pulses on consecutive cycles advance sel once per cycle.
- exit_pulse is high for exactly one cycle, coinciding with the first cycle of adjust=0.

## Configuration
- FIELD_TIMEOUT_EN defined:
  - Inactivity counter and auto-exit are built as described above.
- FIELD_TIMEOUT_EN undefined:
  - No counter is synthesised and TIMEOUT_CYCLES is ignored.
  - ADJUST is left only by center or rst.
  - exit_pulse fires only on center exits.

## Test plan
All scenarios use NUM_FIELDS=4, START_FIELD=0, TIMEOUT_CYCLES=8.
- Reset: rst=1 for 5 cycles, with left/right/center toggling during it → adjust=0, en=4'b0000, sel=0, exit_pulse=0 throughout.
- Entry and forward wrap: center pulse, then 4 right pulses spaced 2 cycles apart → en goes 0001, 0010, 0100, 1000, 0001; adjust=1.
- Backward wrap and simultaneous inputs:
  - From sel=0, a left pulse → en=1000, sel=3.
  - Then left+right together → en stays 1000.
  - Then left+center together → adjust=0, en=0000, exit_pulse=1 for one cycle, sel holds 3.
- Timeout (macro defined):
  - Enter ADJUST and apply no input → adjust falls after exactly 8 ADJUST cycles; exit_pulse=1 once.
  - Repeat, with a right pulse on idle cycle 7 → the exit is pushed out to 8 cycles after that pulse.
- Timeout (macro undefined): enter ADJUST and idle for 100 cycles → adjust stays 1, exit_pulse stays 0.
- Reset mid-operation: at sel=2 in ADJUST, rst=1 for 1 cycle → next cycle adjust=0, en=0000, sel=0, exit_pulse=0.
